max7219_receiver: RTL and testbench

Serial-side model of the MAX7219 display driver: it samples the three-wire SPI stream (`serial_clk`, `serial_dout`, `serial_load`), reassembles 16-bit frames, and decodes them into the MAX7219 register file (digits 0–7, decode mode, intensity, scan limit, shutdown, display test). It sits on the far end of the clock's display output path. It is used for on-chip loopback/self-check and as the synthesizable scoreboard in display benches. All serial inputs are asynchronous to `i_clk` and are oversampled.

---
 rtl/max7219_receiver.sv | 155 +++++++++++++++
 tb/tb_max7219_receiver.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max7219_receiver.sv
// max7219_receiver: serial-side model of the MAX7219 display driver.
// Oversamples the three-wire SCK/DOUT/LOAD stream, rebuilds 16-bit frames
// and decodes committed frames into the MAX7219 register file.

module max7219_receiver #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_serial_clk,
   input  logic        i_serial_dout,
   input  logic        i_serial_load,
   output logic        o_frame_stb,
   output logic        o_frame_err,
   output logic [3:0]  o_addr,
   output logic [7:0]  o_data,
   output logic [63:0] o_digits,
   output logic [7:0]  o_decode_mode,
   output logic [3:0]  o_intensity,
   output logic [2:0]  o_scan_limit,
   output logic        o_shutdown_n,
   output logic        o_display_test
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT   = 2'd1,
      OVERRUN = 2'd2
   } state_t;

   // Bit 0 is the first synchronizer flop; bit SYNC_STAGES-1 is the synchronized
   // value and bit SYNC_STAGES is the history flop used for edge detection.
   logic [SYNC_STAGES:0] sck_chain;
   logic [SYNC_STAGES:0] dout_chain;
   logic [SYNC_STAGES:0] load_chain;

   state_t      state;
   state_t      state_next;
   logic [4:0]  count;
   logic [4:0]  count_next;
   logic [15:0] shreg;
   logic [15:0] shreg_next;
   logic        commit;
   logic        reject;

   logic        sck_rise;
   logic        load_rise;
   logic        load_fall;
   logic        dout_sync;

   // Upper frame bits and the DOUT history flop carry no meaning here.
   logic        unused_bits;
   assign unused_bits = ^{shreg_next[15:12], dout_chain[SYNC_STAGES]};

   assign dout_sync = dout_chain[SYNC_STAGES-1];
   assign sck_rise  =  sck_chain[SYNC_STAGES-1]  & ~sck_chain[SYNC_STAGES];
   assign load_rise =  load_chain[SYNC_STAGES-1] & ~load_chain[SYNC_STAGES];
   assign load_fall = ~load_chain[SYNC_STAGES-1] &  load_chain[SYNC_STAGES];

   // Identical synchronizer chains keep the three serial inputs mutually aligned.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sck_chain  <= '0;
         dout_chain <= '0;
         load_chain <= '0;
      end else begin
         sck_chain  <= {sck_chain[SYNC_STAGES-1:0],  i_serial_clk};
         dout_chain <= {dout_chain[SYNC_STAGES-1:0], i_serial_dout};
         load_chain <= {load_chain[SYNC_STAGES-1:0], i_serial_load};
      end
   end

   // Frame-assembly state, bit count and shift register.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= IDLE;
         count <= '0;
         shreg <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         shreg <= shreg_next;
      end
   end

   // Next-state logic: a SCK edge in the same cycle as a LOAD rise is shifted
   // in first, so the commit check sees the updated count and shift register.
   always_comb begin
      state_next = state;
      count_next = count;
      shreg_next = shreg;
      commit     = 1'b0;
      reject     = 1'b0;
      if (load_fall) begin
         state_next = SHIFT;
         count_next = '0;
         shreg_next = '0;
      end else begin
         if (sck_rise && state != IDLE) begin
            shreg_next = {shreg[14:0], dout_sync};
            if (count >= 5'd16) begin
               count_next = 5'd17;
               state_next = OVERRUN;
            end else begin
               count_next = count + 5'd1;
            end
         end
         if (load_rise && state != IDLE) begin
            state_next = IDLE;
            if (count_next == 5'd16) begin
               commit = 1'b1;
            end else begin
               reject = 1'b1;
            end
         end
      end
   end

   // Register file and strobes update together on the committing edge.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_frame_stb    <= 1'b0;
         o_frame_err    <= 1'b0;
         o_addr         <= '0;
         o_data         <= '0;
         o_digits       <= '0;
         o_decode_mode  <= '0;
         o_intensity    <= '0;
         o_scan_limit   <= '0;
         o_shutdown_n   <= 1'b0;
         o_display_test <= 1'b0;
      end else begin
         o_frame_stb <= commit;
         o_frame_err <= reject;
         if (commit) begin
            o_addr <= shreg_next[11:8];
            o_data <= shreg_next[7:0];
            for (int n = 0; n < 8; n++) begin
               if (shreg_next[11:8] == 4'(n + 1)) begin
                  o_digits[8*n +: 8] <= shreg_next[7:0];
               end
            end
            case (shreg_next[11:8])
               4'h9:    o_decode_mode  <= shreg_next[7:0];
               4'hA:    o_intensity    <= shreg_next[3:0];
               4'hB:    o_scan_limit   <= shreg_next[2:0];
               4'hC:    o_shutdown_n   <= shreg_next[0];
               4'hF:    o_display_test <= shreg_next[0];
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_max7219_receiver.sv
// tb_max7219_receiver: scoreboard bench for the MAX7219 serial receiver.
// Expected strobes are queued as frames are driven and matched when the
// receiver pulses o_frame_stb or o_frame_err.

module tb_max7219_receiver;

   typedef struct packed {
      logic       is_err;
      logic [3:0] addr;
      logic [7:0] data;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        serial_clk;
   logic        serial_dout;
   logic        serial_load;
   logic        frame_stb;
   logic        frame_err;
   logic [3:0]  addr;
   logic [7:0]  data;
   logic [63:0] digits;
   logic [7:0]  decode_mode;
   logic [3:0]  intensity;
   logic [2:0]  scan_limit;
   logic        shutdown_n;
   logic        display_test;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   max7219_receiver #(.SYNC_STAGES(2)) dut (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_serial_clk   (serial_clk),
      .i_serial_dout  (serial_dout),
      .i_serial_load  (serial_load),
      .o_frame_stb    (frame_stb),
      .o_frame_err    (frame_err),
      .o_addr         (addr),
      .o_data         (data),
      .o_digits       (digits),
      .o_decode_mode  (decode_mode),
      .o_intensity    (intensity),
      .o_scan_limit   (scan_limit),
      .o_shutdown_n   (shutdown_n),
      .o_display_test (display_test)
   );

   // 10 MHz system clock.
   initial clk = 1'b0;
   always #50 clk = ~clk;

   // Scoreboard: every strobe pops one expectation and must match it.
   always @(negedge clk) begin
      exp_t e;
      if (reset_n && (frame_stb || frame_err)) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_strobe stb=%0b err=%0b addr=%h data=%h required none", frame_stb, frame_err, addr, data);
         end else begin
            e = exp_q.pop_front();
            if (e.is_err) begin
               if (frame_err !== 1'b1 || frame_stb !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL strobe_kind got stb=%0b err=%0b required err", frame_stb, frame_err);
               end
            end else begin
               if (frame_stb !== 1'b1 || frame_err !== 1'b0 || addr !== e.addr || data !== e.data) begin
                  errors++;
                  $display("[TB] FAIL frame_commit got stb=%0b err=%0b addr=%h data=%h required stb addr=%h data=%h", frame_stb, frame_err, addr, data, e.addr, e.data);
               end
            end
         end
      end
   end

   // Shift the low nbits of word out MSB first with LOAD already low.
   task automatic shift_bits(input logic [31:0] word, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) begin
         serial_dout = word[i];
         repeat (2) @(negedge clk);
         serial_clk = 1'b1;
         repeat (2) @(negedge clk);
         serial_clk = 1'b0;
         @(negedge clk);
      end
   endtask

   // Drive a complete frame of nbits and queue the expected outcome.
   task automatic send_frame(input logic [31:0] word, input int nbits);
      exp_t e;
      e.is_err = (nbits != 16);
      e.addr   = word[11:8];
      e.data   = word[7:0];
      exp_q.push_back(e);
      @(negedge clk);
      serial_load = 1'b0;
      repeat (2) @(negedge clk);
      shift_bits(word, nbits);
      @(negedge clk);
      serial_load = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_reset;
      reset_n     = 1'b0;
      serial_clk  = 1'b0;
      serial_dout = 1'b0;
      serial_load = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (frame_stb !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_strobes got stb=%0b err=%0b required 0 0", frame_stb, frame_err);
      end
      checks++;
      if (digits !== 64'h0 || addr !== 4'h0 || data !== 8'h00) begin
         errors++;
         $display("[TB] FAIL reset_fields got digits=%h addr=%h data=%h required 0", digits, addr, data);
      end
      checks++;
      if (decode_mode !== 8'h00 || intensity !== 4'h0 || scan_limit !== 3'h0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl got dm=%h int=%h sl=%h required 0", decode_mode, intensity, scan_limit);
      end
      checks++;
      if (shutdown_n !== 1'b0 || display_test !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags got sd_n=%0b dt=%0b required 0 0", shutdown_n, display_test);
      end
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_single_frame;
      exp_t e;
      logic stb_seen;
      e.is_err = 1'b0;
      e.addr   = 4'hA;
      e.data   = 8'h07;
      exp_q.push_back(e);
      serial_load = 1'b0;
      repeat (2) @(negedge clk);
      shift_bits(32'h0A07, 16);
      @(negedge clk);
      serial_load = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         stb_seen = frame_stb;
         checks++;
         if (stb_seen !== (k == 3)) begin
            errors++;
            $display("[TB] FAIL stb_latency cycle=%0d got %0b required %0b", k, stb_seen, (k == 3));
         end
      end
      repeat (2) @(negedge clk);
      checks++;
      if (intensity !== 4'h7 || addr !== 4'hA || data !== 8'h07) begin
         errors++;
         $display("[TB] FAIL intensity_frame got int=%h addr=%h data=%h required 7 a 07", intensity, addr, data);
      end
   endtask

   task automatic test_digits;
      send_frame(32'h0305, 16);
      send_frame(32'h08FF, 16);
      send_frame(32'h09F0, 16);
      checks++;
      if (digits !== 64'hFF00_0000_0005_0000) begin
         errors++;
         $display("[TB] FAIL digits got %h required ff00000000050000", digits);
      end
      checks++;
      if (decode_mode !== 8'hF0 || addr !== 4'h9 || data !== 8'hF0) begin
         errors++;
         $display("[TB] FAIL decode_mode got dm=%h addr=%h data=%h required f0 9 f0", decode_mode, addr, data);
      end
   endtask

   task automatic test_bad_length;
      send_frame(32'h0C01, 15);
      send_frame({15'h0, 1'b1, 16'h0C01}, 17);
      checks++;
      if (shutdown_n !== 1'b0 || addr !== 4'h9 || data !== 8'hF0) begin
         errors++;
         $display("[TB] FAIL bad_length_regs got sd_n=%0b addr=%h data=%h required 0 9 f0", shutdown_n, addr, data);
      end
   endtask

   task automatic test_idle_sck;
      for (int p = 0; p < 5; p++) begin
         serial_clk = 1'b1;
         repeat (2) @(negedge clk);
         serial_clk = 1'b0;
         repeat (2) @(negedge clk);
      end
      send_frame(32'h0F01, 16);
      checks++;
      if (display_test !== 1'b1 || addr !== 4'hF || data !== 8'h01) begin
         errors++;
         $display("[TB] FAIL display_test got dt=%0b addr=%h data=%h required 1 f 01", display_test, addr, data);
      end
   endtask

   task automatic test_coincident;
      exp_t e;
      e.is_err = 1'b0;
      e.addr   = 4'hB;
      e.data   = 8'h07;
      exp_q.push_back(e);
      serial_load = 1'b0;
      repeat (2) @(negedge clk);
      shift_bits(32'h0B07 >> 1, 15);
      serial_dout = 1'b1;
      repeat (2) @(negedge clk);
      serial_clk  = 1'b1;
      serial_load = 1'b1;
      repeat (2) @(negedge clk);
      serial_clk = 1'b0;
      repeat (4) @(negedge clk);
      checks++;
      if (scan_limit !== 3'h7 || addr !== 4'hB) begin
         errors++;
         $display("[TB] FAIL coincident got sl=%h addr=%h required 7 b", scan_limit, addr);
      end
   endtask

   task automatic test_reset_mid_frame;
      serial_load = 1'b0;
      repeat (2) @(negedge clk);
      shift_bits(32'h0C01 >> 8, 8);
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      shift_bits(32'h0001, 8);
      @(negedge clk);
      serial_load = 1'b1;
      repeat (5) @(negedge clk);
      checks++;
      if (shutdown_n !== 1'b0 || intensity !== 4'h0 || digits !== 64'h0) begin
         errors++;
         $display("[TB] FAIL reset_mid_frame got sd_n=%0b int=%h digits=%h required 0 0 0", shutdown_n, intensity, digits);
      end
      send_frame(32'h0C01, 16);
      checks++;
      if (shutdown_n !== 1'b1) begin
         errors++;
         $display("[TB] FAIL shutdown_after_reset got %0b required 1", shutdown_n);
      end
   endtask

   initial begin
      test_reset;
      test_single_frame;
      test_digits;
      test_bad_length;
      test_idle_sck;
      test_coincident;
      test_reset_mid_frame;
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL missing_strobes got %0d pending required 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
